// File: rtl/tmp_conv_seq.sv
// Conversion sequencer for the switched-capacitor temperature front end: phi1/phi2 phasing, 1st-order delta-sigma steering, ones-count result.
// Optional chopping of the comparator decision is enabled by defining TMP_CHOP_EN.
module tmp_conv_seq #(
  parameter int OSR_W     = 10,
  parameter int PHASE_LEN = 2,
  parameter int NONOVL    = 1,
  parameter int FERST_LEN = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [OSR_W-1:0] i_osr,
  input  logic             i_cmp,
  output logic             o_phi1,
  output logic             o_phi2,
  output logic             o_src_n,
  output logic             o_snk,
  output logic             o_fe_rst,
  output logic             o_busy,
`ifdef TMP_CHOP_EN
  output logic             o_chop,
`endif
  output logic [OSR_W-1:0] o_result,
  output logic             o_res_valid,
  input  logic             i_res_ready
);

  typedef enum logic [2:0] {
    S_IDLE, S_FERST, S_PHI1, S_GAP1, S_PHI2, S_GAP2, S_DONE
  } state_t;

  localparam int TW = 8;
  localparam logic [TW-1:0] L_PH = TW'(PHASE_LEN - 1);
  localparam logic [TW-1:0] L_NO = TW'(NONOVL - 1);
  localparam logic [TW-1:0] L_FR = TW'(FERST_LEN - 1);

  state_t           r_state;
  logic [TW-1:0]    r_tmr;
  logic [OSR_W-1:0] r_osr;
  logic [OSR_W-1:0] r_cyc;
  logic [OSR_W-1:0] r_ones;
  logic             r_dec;

  logic             w_dec;
  logic             w_accept;
  logic [OSR_W-1:0] w_cyc_nxt;

`ifdef TMP_CHOP_EN
  assign w_dec = i_cmp ^ o_chop;
`else
  assign w_dec = i_cmp;
`endif

  assign w_accept  = i_start && (i_osr != '0) && (!o_res_valid || i_res_ready);
  assign w_cyc_nxt = r_cyc + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_tmr       <= '0;
      r_osr       <= '0;
      r_cyc       <= '0;
      r_ones      <= '0;
      r_dec       <= 1'b0;
      o_phi1      <= 1'b0;
      o_phi2      <= 1'b0;
      o_src_n     <= 1'b1;
      o_snk       <= 1'b0;
      o_fe_rst    <= 1'b0;
      o_busy      <= 1'b0;
      o_result    <= '0;
      o_res_valid <= 1'b0;
`ifdef TMP_CHOP_EN
      o_chop      <= 1'b0;
`endif
    end else begin
      if (o_res_valid && i_res_ready)
        o_res_valid <= 1'b0;

      // abort wins over every in-flight transition, including cycle completion
      if (i_abort && (r_state != S_IDLE) && (r_state != S_DONE)) begin
        r_state  <= S_IDLE;
        r_tmr    <= '0;
        o_phi1   <= 1'b0;
        o_phi2   <= 1'b0;
        o_src_n  <= 1'b1;
        o_snk    <= 1'b0;
        o_fe_rst <= 1'b0;
        o_busy   <= 1'b0;
`ifdef TMP_CHOP_EN
        o_chop   <= 1'b0;
`endif
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              r_osr    <= i_osr;
              r_ones   <= '0;
              r_cyc    <= '0;
              r_tmr    <= '0;
              o_fe_rst <= 1'b1;
              o_busy   <= 1'b1;
              r_state  <= S_FERST;
            end
          end
          S_FERST: begin
            if (r_tmr == L_FR) begin
              r_tmr    <= '0;
              o_fe_rst <= 1'b0;
              o_phi1   <= 1'b1;
`ifdef TMP_CHOP_EN
              o_chop   <= ~o_chop;
`endif
              r_state  <= S_PHI1;
            end else begin
              r_tmr <= r_tmr + 1'b1;
            end
          end
          S_PHI1: begin
            if (r_tmr == L_PH) begin
              r_tmr   <= '0;
              o_phi1  <= 1'b0;
              r_state <= S_GAP1;
            end else begin
              r_tmr <= r_tmr + 1'b1;
            end
          end
          S_GAP1: begin
            if (r_tmr == L_NO) begin
              r_tmr   <= '0;
              r_dec   <= w_dec;
              r_ones  <= r_ones + OSR_W'(w_dec);
              o_phi2  <= 1'b1;
              o_src_n <= ~w_dec;
              o_snk   <= ~w_dec;
              r_state <= S_PHI2;
            end else begin
              r_tmr <= r_tmr + 1'b1;
            end
          end
          S_PHI2: begin
            if (r_tmr == L_PH) begin
              r_tmr   <= '0;
              o_phi2  <= 1'b0;
              o_src_n <= 1'b1;
              o_snk   <= 1'b0;
              r_state <= S_GAP2;
            end else begin
              r_tmr   <= r_tmr + 1'b1;
              o_src_n <= ~r_dec;
              o_snk   <= ~r_dec;
            end
          end
          S_GAP2: begin
            if (r_tmr == L_NO) begin
              r_tmr <= '0;
              r_cyc <= w_cyc_nxt;
              if (w_cyc_nxt == r_osr) begin
                r_state <= S_DONE;
              end else begin
                o_phi1  <= 1'b1;
`ifdef TMP_CHOP_EN
                o_chop  <= ~o_chop;
`endif
                r_state <= S_PHI1;
              end
            end else begin
              r_tmr <= r_tmr + 1'b1;
            end
          end
          S_DONE: begin
            o_result    <= r_ones;
            o_res_valid <= 1'b1;
            o_busy      <= 1'b0;
`ifdef TMP_CHOP_EN
            o_chop      <= 1'b0;
`endif
            r_state     <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tmp_conv_seq.sv
// Self-checking bench for tmp_conv_seq: directed runs with random comparator patterns against a ones-count model.
module tb_tmp_conv_seq;
  localparam int OSR_W     = 10;
  localparam int PHASE_LEN = 2;
  localparam int NONOVL    = 1;
  localparam int FERST_LEN = 2;

  logic             clk = 1'b0;
  logic             reset, start, abort, cmp, res_ready;
  logic [OSR_W-1:0] osr;
  logic             phi1, phi2, src_n, snk, fe_rst, busy, res_valid;
  logic [OSR_W-1:0] result;
`ifdef TMP_CHOP_EN
  logic             chop;
  logic [15:0]      chop_hist = '0;
`endif

  int errors = 0;
  int checks = 0;
  bit pat [64];
  int base = 0;
  int win_total = 0, src_total = 0, snk_total = 0, viol_total = 0;
  bit prev_p1 = 1'b0, prev_p2 = 1'b0;
  int exp_res = 0;

  tmp_conv_seq #(.OSR_W(OSR_W), .PHASE_LEN(PHASE_LEN), .NONOVL(NONOVL), .FERST_LEN(FERST_LEN)) dut (
    .clk(clk), .reset(reset), .i_start(start), .i_abort(abort), .i_osr(osr), .i_cmp(cmp),
    .o_phi1(phi1), .o_phi2(phi2), .o_src_n(src_n), .o_snk(snk), .o_fe_rst(fe_rst), .o_busy(busy),
`ifdef TMP_CHOP_EN
    .o_chop(chop),
`endif
    .o_result(result), .o_res_valid(res_valid), .i_res_ready(res_ready)
  );

  always #5 clk = ~clk;

  // Front-end observer: counts phi2 windows and charge clocks, flags overlap, feeds cmp per cycle.
  always @(negedge clk) begin
    if (reset) begin
      prev_p1 = 1'b0;
      prev_p2 = 1'b0;
    end else begin
      if (phi2 && !prev_p2) win_total++;
      if (!src_n) src_total++;
      if (snk) snk_total++;
      if ((phi1 && phi2) || (!src_n && snk) || ((!src_n || snk) && !phi2) ||
          (phi2 && prev_p1) || (phi1 && prev_p2))
        viol_total++;
`ifdef TMP_CHOP_EN
      if (phi1 && !prev_p1) chop_hist = {chop_hist[14:0], chop};
`endif
      prev_p1 = phi1;
      prev_p2 = phi2;
    end
    cmp = pat[(win_total - base) % 64];
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_ones(input int n);
    int s = 0;
    for (int k = 0; k < n; k++) begin
      bit d = pat[k];
`ifdef TMP_CHOP_EN
      d = d ^ (k % 2 == 0);
`endif
      s += int'(d);
    end
    return s;
  endfunction

  task automatic run_conv(input int n, input bit keep_valid, input bit rdy_at_start);
    int lat, w0, s0, k0, v0, ones;
    @(negedge clk);
    base = win_total;
    w0 = win_total; s0 = src_total; k0 = snk_total; v0 = viol_total;
    osr = OSR_W'(n);
    start = 1'b1;
    res_ready = rdy_at_start;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    res_ready = 1'b0;
    chk("busy_after_accept", busy, 1);
    chk("valid_after_accept", res_valid, 0);
    chk("fe_rst_after_accept", fe_rst, 1);
    lat = 0;
    while (!res_valid && lat < 2000) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    #1;
    ones = exp_ones(n);
    exp_res = ones;
    chk("latency", lat, FERST_LEN + n * (2 * PHASE_LEN + 2 * NONOVL) + 1);
    chk("result", int'(result), ones);
    chk("phi2_windows", win_total - w0, n);
    chk("src_n_low_clks", src_total - s0, PHASE_LEN * ones);
    chk("snk_high_clks", snk_total - k0, PHASE_LEN * (n - ones));
    chk("overlap_violations", viol_total - v0, 0);
    chk("busy_at_done", busy, 0);
    if (!keep_valid) begin
      @(negedge clk);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk("valid_drained", res_valid, 0);
    end
  endtask

  initial begin
    int t, n;
    reset = 1'b1; start = 1'b0; abort = 1'b0; res_ready = 1'b0; osr = '0;
    for (int k = 0; k < 64; k++) pat[k] = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_phi1", phi1, 0);
    chk("rst_phi2", phi2, 0);
    chk("rst_src_n", src_n, 1);
    chk("rst_snk", snk, 0);
    chk("rst_fe_rst", fe_rst, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", int'(result), 0);
    chk("rst_res_valid", res_valid, 0);
    reset = 1'b0;

    // basic: cmp=1, osr=4, result left pending
    for (int k = 0; k < 64; k++) pat[k] = 1'b1;
    run_conv(4, 1'b1, 1'b0);

    // start under backpressure is ignored
    @(negedge clk);
    osr = 3; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("bp_busy", busy, 0);
    chk("bp_valid_held", res_valid, 1);
    chk("bp_result_held", int'(result), exp_res);

    // ready raised with start; zero input
    for (int k = 0; k < 64; k++) pat[k] = 1'b0;
    run_conv(8, 1'b0, 1'b1);

    // osr=0 start ignored
    @(negedge clk);
    osr = 0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("osr0_ignored", busy, 0);

    // alternating comparator
    for (int k = 0; k < 64; k++) pat[k] = (k % 2 == 0);
    run_conv(10, 1'b0, 1'b0);

    // random comparator patterns
    repeat (4) begin
      for (int k = 0; k < 64; k++) pat[k] = 1'($urandom % 2);
      n = $urandom_range(1, 12);
      run_conv(n, 1'b0, 1'b0);
    end

    // abort in the 3rd phi2 window of an osr=6 run
    for (int k = 0; k < 64; k++) pat[k] = 1'b1;
    @(negedge clk);
    base = win_total;
    osr = 6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    #1;
    while ((win_total - base) < 3 && t < 500) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("abort_reached_phi2", win_total - base, 3);
    chk("abort_in_phi2", phi2, 1);
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    chk("abort_phi1", phi1, 0);
    chk("abort_phi2", phi2, 0);
    chk("abort_src_n", src_n, 1);
    chk("abort_snk", snk, 0);
    chk("abort_fe_rst", fe_rst, 0);
    chk("abort_busy", busy, 0);
    chk("abort_valid", res_valid, 0);
    chk("abort_result_kept", int'(result), exp_res);
`ifdef TMP_CHOP_EN
    chk("abort_chop", chop, 0);
`endif
    run_conv(2, 1'b0, 1'b0);

`ifdef TMP_CHOP_EN
    chop_hist = '0;
    run_conv(4, 1'b0, 1'b0);
    chk("chop_sequence", int'(chop_hist[3:0]), 4'b1010);
    chk("chop_after_done", chop, 0);
`endif

    // reset in the middle of a conversion publishes nothing
    @(negedge clk);
    osr = 5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_phi", int'({phi1, phi2}), 0);
    chk("midrst_src_n", src_n, 1);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("midrst_valid", res_valid, 0);
    chk("midrst_result", int'(result), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tmp_conv_seq.md
Name: tmp_conv_seq

Overview:
Conversion sequencer for the switched-capacitor temperature front end.
- Runs a programmable number of measurement cycles. Each cycle has two non-overlapping clock phases (phi1/phi2) with blanking gaps between them.
- Samples the comparator once per cycle and drives the charge source/sink during phi2 according to that decision (first-order delta-sigma loop).
- Accumulates the ones-count as the conversion result and hands it to the register/readout layer over a valid/ready handshake.

Parameters:
- OSR_W, 10: width of osr input, internal cycle counter and result.
- PHASE_LEN, 2: clocks each of phi1 and phi2 is held high (>=1).
- NONOVL, 1: blank clocks after each phase, both phases low (>=1).
- FERST_LEN, 2: clocks fe_rst is held high at conversion start (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a conversion (single-cycle pulse or level).
- abort  in  1  terminate the running conversion.
- osr  in  OSR_W  number of measurement cycles; latched on start acceptance.
- cmp  in  1  comparator output, already synchronised.
- phi1  out  1  front-end phase 1.
- phi2  out  1  front-end phase 2.
- src_n  out  1  charge source enable, active-low.
- snk  out  1  charge sink enable, active-high.
- fe_rst  out  1  front-end integrator reset.
- busy  out  1  conversion in progress.
- result  out  OSR_W  ones-count of the last conversion.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.

Behaviour:
- Reset values (asynchronous): phi1=0, phi2=0, src_n=1, snk=0, fe_rst=0, busy=0, result=0, res_valid=0, state=IDLE, counters=0.
- States: IDLE, FERST, PHI1, GAP1, PHI2, GAP2, DONE. All outputs are registered.
- IDLE:
  - start is accepted when start=1, osr!=0, and (res_valid=0 or res_ready=1).
  - On acceptance: latch osr, clear the ones and cycle counters, go to FERST, set busy=1.
  - start with osr=0 is ignored.
  - start while busy=1 is ignored.
- FERST: fe_rst=1 for FERST_LEN clocks, then go to PHI1 with fe_rst=0.
- PHI1: phi1=1 for PHASE_LEN clocks, then go to GAP1.
- GAP1: phi1=phi2=0 for NONOVL clocks. On the edge leaving GAP1, register dec=cmp.
- PHI2: phi2=1 for PHASE_LEN clocks.
  - dec=1: src_n=0, snk=0.
  - dec=0: src_n=1, snk=1.
  - The ones counter increments by dec on the edge entering PHI2.
- GAP2: phi2=0, src_n=1, snk=0 for NONOVL clocks. Then cycle counter +1.
  - If the count equals the latched osr: go to DONE.
  - Otherwise: go to PHI1.
- DONE (one clock): result <= ones count, res_valid <= 1, busy <= 0, go to IDLE.
- Handshake:
  - res_valid stays high and result stays stable until a clock with res_ready=1, which clears res_valid.
  - If an accepted start coincides with res_ready=1, res_valid is cleared and the new conversion starts on the same edge.
- Latency: res_valid rises on edge FERST_LEN + osr*(2*PHASE_LEN + 2*NONOVL) + 1 after the start-acceptance edge. With defaults this is 3 + 6*osr.
- Width: the ones count never exceeds osr, so it cannot wrap. Maximum osr = 2^OSR_W - 1.
- Non-overlap is guaranteed:
  - phi1 and phi2 are never high in the same clock.
  - src_n=0 and snk=1 never occur together.
  - src_n/snk are asserted only while phi2=1.
- abort (any state other than IDLE/DONE): on the next edge go to IDLE. All phase and charge outputs return to their reset values, busy=0, result and res_valid are unchanged. abort has priority over the cycle-complete transition.
- Reset mid-operation: immediate return to the reset values; no partial result is published.

Optional Feature:
- Macro TMP_CHOP_EN.
- Defined:
  - Adds output port chop (1 bit, reset 0).
  - chop toggles on each edge entering PHI1 (first cycle chop=1).
  - The effective decision is dec = cmp XOR chop, used for both src_n/snk steering and the ones count.
  - chop returns to 0 on abort, DONE and reset.
- Undefined: no chop port; dec = cmp.

Test Plan:
- Basic: cmp=1 constant, osr=4, start pulse.
  - Response: res_valid rises 27 edges after acceptance, result=4.
  - src_n low for 2 clocks in each of 4 phi2 windows; snk never high.
- Zero input: cmp=0 constant, osr=8.
  - Response: result=0; snk high 2 clocks per phi2 window, 8 windows; src_n stays 1.
- Alternating: cmp toggles each cycle (1,0,1,...), osr=10.
  - Response: result=5.
  - Checker confirms phi1 and phi2 are never both high, and at least 1 blank clock between phases.
- Backpressure: res_ready=0, new start after DONE.
  - Response: start ignored, result held.
  - Raise res_ready together with start: res_valid drops, busy=1 on the same edge.
- Abort: abort at the 3rd PHI2 of an osr=6 run.
  - Response: next edge phi/src_n/snk/busy are at reset values; res_valid stays 0.
  - A subsequent start with osr=2, cmp=1 gives result=2.
- Chop (TMP_CHOP_EN): cmp=1 constant, osr=4.
  - Response: chop sequence 1,0,1,0; result=2.
